vga_timing_gen: RTL and testbench

//  Generates 640x480@60 VGA raster timing. It sits between clockdiv and the VGA

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_if.sv | 22 ++
 rtl/vga_axis_ctr.sv | 41 ++++
 rtl/vga_timing_gen.sv | 81 ++++++++
 tb/tb_vga_timing_gen.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants; imported by the timing generator and the
// colour stage.
package vga_pkg;

  localparam int unsigned CW      = 10;
  localparam int unsigned CW_SPAN = 2 ** CW;
  localparam int unsigned FCW     = 8;

  localparam int unsigned H_VIS  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VIS  = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic H_POL = 1'b0;
  localparam logic V_POL = 1'b0;

  typedef logic [CW-1:0] coord_t;

endpackage

// File: rtl/vga_if.sv
// Registered raster outputs handed from the timing generator to the colour stage.
interface vga_if;
  import vga_pkg::*;

  logic           hsync;
  logic           vsync;
  logic           video_on;
  coord_t         hcount;
  coord_t         vcount;
  logic           line_start;
  logic           frame_start;
  logic [FCW-1:0] frame_cnt;

  modport master (
    output hsync, vsync, video_on, hcount, vcount, line_start, frame_start, frame_cnt
  );

  modport slave (
    input hsync, vsync, video_on, hcount, vcount, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_axis_ctr.sv
// One raster axis: wrap counter plus combinational sync, visible and edge decode.
module vga_axis_ctr
  import vga_pkg::*;
#(
  parameter int unsigned TOT  = H_TOT,
  parameter int unsigned VIS  = H_VIS,
  parameter int unsigned FP   = H_FP,
  parameter int unsigned SYNC = H_SYNC,
  parameter logic        POL  = H_POL
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  output coord_t ctr,
  output logic   first,
  output logic   last,
  output logic   sync,
  output logic   vis
);

  localparam coord_t LAST_C  = coord_t'(TOT - 1);
  localparam coord_t SYNC_LO = coord_t'(VIS + FP);
  localparam coord_t SYNC_HI = coord_t'(VIS + FP + SYNC);
  localparam coord_t VIS_END = coord_t'(VIS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= '0;
    end else if (inc) begin
      ctr <= last ? '0 : ctr + 1'b1;
    end
  end

  always_comb begin
    first = (ctr == '0);
    last  = (ctr == LAST_C);
    sync  = (ctr >= SYNC_LO && ctr < SYNC_HI) ? POL : ~POL;
    vis   = (ctr < VIS_END);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: two axis counters feeding one aligned output register bank
// plus the completed-frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VIS  = vga_pkg::H_VIS,
  parameter int unsigned H_FP   = vga_pkg::H_FP,
  parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
  parameter int unsigned H_BP   = vga_pkg::H_BP,
  parameter int unsigned V_VIS  = vga_pkg::V_VIS,
  parameter int unsigned V_FP   = vga_pkg::V_FP,
  parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
  parameter int unsigned V_BP   = vga_pkg::V_BP,
  parameter logic        H_POL  = vga_pkg::H_POL,
  parameter logic        V_POL  = vga_pkg::V_POL
) (
  input  logic  dclk,
  input  logic  clr,
  input  logic  ce,
  vga_if.master vid
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  import vga_pkg::*;

  if (H_TOTAL > CW_SPAN || V_TOTAL > CW_SPAN) begin : g_tot_check
    $error("vga_timing_gen: line or frame total exceeds the coordinate range");
  end

  coord_t h_ctr, v_ctr;
  logic   h_first, h_last, h_sync, h_vis;
  logic   v_first, v_last, v_sync, v_vis;
  logic   frame_done;

  vga_axis_ctr #(
    .TOT(H_TOTAL), .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .POL(H_POL)
  ) u_h (
    .clk(dclk), .rst_n(clr), .inc(ce),
    .ctr(h_ctr), .first(h_first), .last(h_last), .sync(h_sync), .vis(h_vis)
  );

  vga_axis_ctr #(
    .TOT(V_TOTAL), .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .POL(V_POL)
  ) u_v (
    .clk(dclk), .rst_n(clr), .inc(ce & h_last),
    .ctr(v_ctr), .first(v_first), .last(v_last), .sync(v_sync), .vis(v_vis)
  );

  // frame_done marks that the last pixel of a frame has been emitted, so the
  // very first frame after reset never bumps frame_cnt.
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      vid.hcount      <= '0;
      vid.vcount      <= '0;
      vid.hsync       <= ~H_POL;
      vid.vsync       <= ~V_POL;
      vid.video_on    <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.frame_cnt   <= '0;
      frame_done      <= 1'b0;
    end else if (ce) begin
      vid.hcount      <= h_ctr;
      vid.vcount      <= v_ctr;
      vid.hsync       <= h_sync;
      vid.vsync       <= v_sync;
      vid.video_on    <= h_vis & v_vis;
      vid.line_start  <= h_first;
      vid.frame_start <= h_first & v_first;
      if (h_first && v_first) begin
        if (frame_done) begin
          vid.frame_cnt <= vid.frame_cnt + 1'b1;
        end
        frame_done <= 1'b0;
      end else if (h_last && v_last) begin
        frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 640x480 instance plus a reduced-raster instance
// so frame and wrap behaviour fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;
  } out_t;

  typedef struct {
    int unsigned hv, hf, hs, hb, vv, vf, vs, vb;
    logic        hp, vp;
  } geom_t;

  logic dclk = 1'b0;
  logic clr  = 1'b1;
  logic ce   = 1'b0;

  int unsigned k      = 0;  // ce edges accepted since reset release
  int unsigned checks = 0;
  int unsigned fails  = 0;
  geom_t gf, gs;

  always #5 dclk = ~dclk;

  vga_if vf ();
  vga_if vs ();

  vga_timing_gen u_full (.dclk(dclk), .clr(clr), .ce(ce), .vid(vf));

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b1)
  ) u_small (.dclk(dclk), .clr(clr), .ce(ce), .vid(vs));

  // Output k describes raster pixel k-1 counted linearly from reset.
  function automatic out_t model(input int unsigned kk, input geom_t g);
    out_t o;
    int unsigned ht, vt, p, h, v;
    o        = '0;
    o.hsync  = ~g.hp;
    o.vsync  = ~g.vp;
    if (kk == 0) return o;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    p  = kk - 1;
    h  = p % ht;
    v  = (p / ht) % vt;
    o.hcount      = 10'(h);
    o.vcount      = 10'(v);
    o.hsync       = (h >= g.hv + g.hf && h < g.hv + g.hf + g.hs) ? g.hp : ~g.hp;
    o.vsync       = (v >= g.vv + g.vf && v < g.vv + g.vf + g.vs) ? g.vp : ~g.vp;
    o.video_on    = (h < g.hv) && (v < g.vv);
    o.line_start  = (h == 0);
    o.frame_start = (h == 0) && (v == 0);
    o.frame_cnt   = 8'((p / (ht * vt)) % 256);
    return o;
  endfunction

  function automatic out_t get_full();
    out_t o;
    o.hsync = vf.hsync; o.vsync = vf.vsync; o.video_on = vf.video_on;
    o.hcount = vf.hcount; o.vcount = vf.vcount; o.line_start = vf.line_start;
    o.frame_start = vf.frame_start; o.frame_cnt = vf.frame_cnt;
    return o;
  endfunction

  function automatic out_t get_small();
    out_t o;
    o.hsync = vs.hsync; o.vsync = vs.vsync; o.video_on = vs.video_on;
    o.hcount = vs.hcount; o.vcount = vs.vcount; o.line_start = vs.line_start;
    o.frame_start = vs.frame_start; o.frame_cnt = vs.frame_cnt;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("h=%0d v=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d",
                     o.hcount, o.vcount, o.hsync, o.vsync, o.video_on,
                     o.line_start, o.frame_start, o.frame_cnt);
  endfunction

  task automatic tick();
    @(posedge dclk);
    if (clr && ce) k++;
    #1;
  endtask

  task automatic test_reset();
    out_t af, as, ef, es;
    ce = 1'b1;
    #1 clr = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      af = get_full(); as = get_small();
      ef = model(0, gf); es = model(0, gs);
      checks++;
      if (af !== ef) begin fails++; $display("FAIL reset_full got %s exp %s", fmt(af), fmt(ef)); end
      checks++;
      if (as !== es) begin fails++; $display("FAIL reset_small got %s exp %s", fmt(as), fmt(es)); end
    end
    clr = 1'b1;
    tick();
    af = get_full(); as = get_small();
    ef = model(k, gf); es = model(k, gs);
    checks++;
    if (af !== ef) begin fails++; $display("FAIL first_ce_full got %s exp %s", fmt(af), fmt(ef)); end
    checks++;
    if (as !== es) begin fails++; $display("FAIL first_ce_small got %s exp %s", fmt(as), fmt(es)); end
    checks++;
    if (af.frame_start !== 1'b1 || af.hcount !== 10'd0 || af.vcount !== 10'd0 || af.video_on !== 1'b1)
    begin fails++; $display("FAIL first_frame_start got %s exp fs=1 h=0 v=0 von=1", fmt(af)); end
  endtask

  task automatic test_line_timing();
    out_t af, as, ef, es;
    int unsigned hs_start = 9999, hs_len = 0, run = 0, von_fall = 9999;
    int unsigned ls_last = 0, ls_period = 0;
    logic prev_hs, prev_von;
    bit in_pulse = 0, ls_seen = 0;
    prev_hs = vf.hsync; prev_von = vf.video_on;
    for (int unsigned n = 1; n <= 1700; n++) begin
      ce = 1'b1;
      tick();
      af = get_full(); as = get_small();
      ef = model(k, gf); es = model(k, gs);
      checks++;
      if (af !== ef) begin fails++; $display("FAIL line_full k=%0d got %s exp %s", k, fmt(af), fmt(ef)); end
      checks++;
      if (as !== es) begin fails++; $display("FAIL line_small k=%0d got %s exp %s", k, fmt(as), fmt(es)); end
      if (prev_hs && !af.hsync) begin in_pulse = 1; run = 1; hs_start = af.hcount; end
      else if (in_pulse && !af.hsync) run++;
      else if (in_pulse && af.hsync) begin in_pulse = 0; if (hs_len == 0) hs_len = run; end
      if (prev_von && !af.video_on && von_fall == 9999) von_fall = af.hcount;
      if (af.line_start) begin
        if (ls_seen) ls_period = n - ls_last;
        ls_last = n; ls_seen = 1;
      end
      prev_hs = af.hsync; prev_von = af.video_on;
    end
    checks++;
    if (hs_len !== 96) begin fails++; $display("FAIL hsync_width got %0d exp 96", hs_len); end
    checks++;
    if (hs_start !== 656) begin fails++; $display("FAIL hsync_start got %0d exp 656", hs_start); end
    checks++;
    if (von_fall !== 640) begin fails++; $display("FAIL video_on_fall got %0d exp 640", von_fall); end
    checks++;
    if (ls_period !== 800) begin fails++; $display("FAIL line_period got %0d exp 800", ls_period); end
  endtask

  task automatic test_frame_timing();
    out_t af, as, ef, es;
    int unsigned vs_len = 0, run = 0, vs_startv = 99, vs_starth = 99;
    int unsigned fs_last = 0, fs_period = 0;
    logic prev_act, act;
    bit in_pulse = 0, fs_seen = 0;
    prev_act = (vs.vsync == gs.vp);
    for (int unsigned n = 1; n <= 480; n++) begin
      ce = 1'b1;
      tick();
      af = get_full(); as = get_small();
      ef = model(k, gf); es = model(k, gs);
      checks++;
      if (af !== ef) begin fails++; $display("FAIL frame_full k=%0d got %s exp %s", k, fmt(af), fmt(ef)); end
      checks++;
      if (as !== es) begin fails++; $display("FAIL frame_small k=%0d got %s exp %s", k, fmt(as), fmt(es)); end
      act = (as.vsync == gs.vp);
      if (!prev_act && act) begin in_pulse = 1; run = 1; vs_startv = as.vcount; vs_starth = as.hcount; end
      else if (in_pulse && act) run++;
      else if (in_pulse && !act) begin in_pulse = 0; if (vs_len == 0) vs_len = run; end
      if (as.frame_start) begin
        if (fs_seen) fs_period = n - fs_last;
        fs_last = n; fs_seen = 1;
      end
      prev_act = act;
    end
    checks++;
    if (vs_len !== 32) begin fails++; $display("FAIL vsync_width got %0d exp 32", vs_len); end
    checks++;
    if (vs_startv !== 7 || vs_starth !== 0)
    begin fails++; $display("FAIL vsync_start got v=%0d h=%0d exp v=7 h=0", vs_startv, vs_starth); end
    checks++;
    if (fs_period !== 160) begin fails++; $display("FAIL frame_period got %0d exp 160", fs_period); end
  endtask

  task automatic test_ce_gating();
    out_t af, as, ef, es, pf, ps;
    int unsigned run = 0, ls_len = 0, rise_last = 0, rise_period = 0;
    logic prev_ls;
    bit in_pulse = 0, rise_seen = 0;
    pf = get_full(); ps = get_small(); prev_ls = pf.line_start;
    for (int unsigned n = 0; n < 9000; n++) begin
      ce = (n < 7000) ? (n % 4 == 0) : 1'($urandom_range(0, 1));
      tick();
      af = get_full(); as = get_small();
      ef = model(k, gf); es = model(k, gs);
      checks++;
      if (af !== ef) begin fails++; $display("FAIL ce_full k=%0d got %s exp %s", k, fmt(af), fmt(ef)); end
      checks++;
      if (as !== es) begin fails++; $display("FAIL ce_small k=%0d got %s exp %s", k, fmt(as), fmt(es)); end
      if (!ce) begin
        checks++;
        if (af !== pf || as !== ps)
        begin fails++; $display("FAIL ce_hold got %s / %s exp %s / %s", fmt(af), fmt(as), fmt(pf), fmt(ps)); end
      end
      if (n < 7000) begin
        if (!prev_ls && af.line_start) begin
          in_pulse = 1; run = 1;
          if (rise_seen) rise_period = n - rise_last;
          rise_last = n; rise_seen = 1;
        end else if (in_pulse && af.line_start) run++;
        else if (in_pulse && !af.line_start) begin in_pulse = 0; if (ls_len == 0) ls_len = run; end
      end
      prev_ls = af.line_start; pf = af; ps = as;
    end
    ce = 1'b1;
    checks++;
    if (ls_len !== 4) begin fails++; $display("FAIL ce_line_start_width got %0d exp 4", ls_len); end
    checks++;
    if (rise_period !== 3200) begin fails++; $display("FAIL ce_line_period got %0d exp 3200", rise_period); end
  endtask

  task automatic test_wrap();
    out_t af, as, ef, es;
    int unsigned fs_count = 0, maxhf = 0, maxvf = 0, maxhs = 0, maxvs = 0;
    logic [7:0] last_fc = '0;
    bit saw255 = 0, wrap_seen = 0;
    ce = 1'b1;
    clr = 1'b0; k = 0;
    tick();
    clr = 1'b1;
    for (int unsigned n = 1; n <= 41120; n++) begin
      tick();
      af = get_full(); as = get_small();
      ef = model(k, gf); es = model(k, gs);
      checks++;
      if (af !== ef) begin fails++; $display("FAIL wrap_full k=%0d got %s exp %s", k, fmt(af), fmt(ef)); end
      checks++;
      if (as !== es) begin fails++; $display("FAIL wrap_small k=%0d got %s exp %s", k, fmt(as), fmt(es)); end
      if (af.hcount > maxhf) maxhf = af.hcount;
      if (af.vcount > maxvf) maxvf = af.vcount;
      if (as.hcount > maxhs) maxhs = as.hcount;
      if (as.vcount > maxvs) maxvs = as.vcount;
      if (as.frame_start) begin
        if (fs_count > 0 && last_fc == 8'd255) begin
          wrap_seen = 1;
          checks++;
          if (as.frame_cnt !== 8'd0) begin fails++; $display("FAIL frame_cnt_wrap got %0d exp 0", as.frame_cnt); end
        end
        if (as.frame_cnt == 8'd255) saw255 = 1;
        last_fc = as.frame_cnt;
        fs_count++;
      end
    end
    checks++;
    if (!saw255 || !wrap_seen) begin fails++; $display("FAIL frame_cnt_255_then_0 got saw255=%0d wrap=%0d exp 1 1", saw255, wrap_seen); end
    checks++;
    if (fs_count !== 257) begin fails++; $display("FAIL frame_start_count got %0d exp 257", fs_count); end
    checks++;
    if (maxhf !== 799 || maxvf > 524) begin fails++; $display("FAIL full_max got h=%0d v=%0d exp h=799 v<=524", maxhf, maxvf); end
    checks++;
    if (maxhs !== 15 || maxvs !== 9) begin fails++; $display("FAIL small_max got h=%0d v=%0d exp h=15 v=9", maxhs, maxvs); end
  endtask

  task automatic test_mid_reset();
    out_t af, as, ef, es;
    int unsigned th, tv, budget;
    bit hit = 0;
    th = $urandom_range(0, 799);
    tv = $urandom_range(1, 2);
    ce = 1'b1;
    clr = 1'b0; k = 0;
    tick();
    clr = 1'b1;
    for (budget = 0; budget < 3000 && !hit; budget++) begin
      tick();
      if (vf.hcount == 10'(th) && vf.vcount == 10'(tv)) hit = 1;
    end
    checks++;
    if (!hit) begin fails++; $display("FAIL mid_reset_reach got timeout exp h=%0d v=%0d", th, tv); end
    #2 clr = 1'b0;
    k = 0;
    #1;
    af = get_full(); as = get_small();
    ef = model(0, gf); es = model(0, gs);
    checks++;
    if (af !== ef) begin fails++; $display("FAIL async_clear_full got %s exp %s", fmt(af), fmt(ef)); end
    checks++;
    if (as !== es) begin fails++; $display("FAIL async_clear_small got %s exp %s", fmt(as), fmt(es)); end
    for (int i = 0; i < 3; i++) begin
      ce = 1'($urandom_range(0, 1));
      tick();
      af = get_full();
      checks++;
      if (af !== ef) begin fails++; $display("FAIL held_reset got %s exp %s", fmt(af), fmt(ef)); end
    end
    clr = 1'b1;
    for (int unsigned n = 0; n < 200; n++) begin
      ce = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      af = get_full(); as = get_small();
      ef = model(k, gf); es = model(k, gs);
      checks++;
      if (af !== ef) begin fails++; $display("FAIL restart_full k=%0d got %s exp %s", k, fmt(af), fmt(ef)); end
      checks++;
      if (as !== es) begin fails++; $display("FAIL restart_small k=%0d got %s exp %s", k, fmt(as), fmt(es)); end
      if (n == 0) begin
        checks++;
        if (af.hcount !== 10'd0 || af.vcount !== 10'd0 || af.frame_start !== 1'b1)
        begin fails++; $display("FAIL restart_origin got %s exp h=0 v=0 fs=1", fmt(af)); end
      end
    end
  endtask

  initial begin
    gf = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    gs = '{8, 2, 3, 3, 6, 1, 2, 1, 1'b0, 1'b1};
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_ce_gating();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
